ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the first-generation keyboard receiver.
- Adds a glitch filter on ps2_clk, a frame timeout, a parity/framing error report and a configurable FIFO depth.
- Optionally folds the E0/F0 prefix bytes into flags attached to the following scan code.
- Sits between the PS/2 pins and the keyboard/terminal logic; output is a first-word-fall-through FIFO with an active-high pop.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth = 2**FIFO_AW entries)
FILTER_LEN, 4, consecutive equal synchronised ps2_clk samples required before the filtered clock changes
TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge that abort a partial frame
MERGE_PREFIX, 1, 1 = absorb E0/F0 into flags; 0 = push every byte raw with flags 0

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
rd_en  in  1  pop head entry when valid
clr_err  in  1  clears overflow, parity_err and frame_err
data  out  8  head scan code (valid only when valid=1)
is_ext  out  1  head entry was preceded by E0
is_break  out  1  head entry was preceded by F0
valid  out  1  FIFO not empty
count  out  FIFO_AW+1  entries held
overflow  out  1  sticky: a byte was dropped because the FIFO was full
parity_err  out  1  sticky: a frame failed odd parity
frame_err  out  1  sticky: bad stop bit or timeout

Behaviour:
- Reset (clrn=0, asynchronous) clears:
  - all outputs: valid=0, count=0, data/is_ext/is_break=0, all error flags=0
  - internal state: pointers, bit counter, pending flags, timeout counter; filtered clock is set to 1.
- Input path: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filter: the filtered clock takes the synchronised value after FILTER_LEN consecutive identical samples.
- Sample event: the cycle in which the filtered clock goes 1->0. ps2_data is sampled from the synchronised value in that cycle.
- Frame FSM states: IDLE, DATA (8 bits, LSB first), PARITY, STOP.
  - IDLE: sample=0 -> DATA. sample=1 -> stay IDLE (resync, no error).
  - DATA: shift in 8 bits, then -> PARITY. PARITY: store bit -> STOP.
  - STOP: requires stop=1 and the XOR of the 8 data bits plus parity = 1.
    - Parity bad -> parity_err=1, byte discarded.
    - Stop=0 (parity good) -> frame_err=1, byte discarded.
    - Both bad -> both flags set.
    - Always return to IDLE.
- Timeout: in any state other than IDLE, a counter runs and is cleared on every sample event. Reaching TIMEOUT_CYCLES forces IDLE, sets frame_err=1 and discards the partial byte.
- Prefix merge (MERGE_PREFIX=1), applied to a good byte:
  - E0 sets pend_ext; F0 sets pend_brk. Neither is pushed.
  - Any other byte is pushed with {pend_ext, pend_brk}, then both pending flags clear.
  - A discarded frame also clears both pending flags.
  - E1 gets no special treatment.
- Latency: a good byte is written on the cycle after its stop-bit sample event. valid/data reflect it on the following cycle, i.e. two cycles after the sample event when the FIFO was empty.
- FIFO:
  - Head appears combinationally on data/is_ext/is_break.
  - Pop: rd_en with valid=1 advances the read pointer. rd_en with valid=0 is ignored.
  - Full push without a pop that cycle: byte dropped, overflow=1, FIFO contents unchanged.
  - Full push with a simultaneous pop: push accepted; count stays at depth.
  - Pointers wrap modulo depth; count saturates at neither end by construction.
- Errors: the three sticky flags set on their events. clr_err clears them; a set event in the same cycle wins.
- Mid-frame reset: FSM returns to IDLE and the partial byte is lost. The next valid start bit is accepted normally.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE/DATA/PARITY/STOP)
  - prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0
  - FIFO entry struct {ext, brk, code[7:0]}
- One sub-module, ps2_clk_filter: synchroniser + FILTER_LEN filter + falling-edge pulse.
- FSM and FIFO stay in the top module.

Test Plan:
1. Frame 0x1C (parity bit 0, stop 1) -> valid=1, data=8'h1C, is_ext=0, is_break=0, count=1. rd_en for 1 cycle -> valid=0.
2. Frame sequence E0, F0, 74 with MERGE_PREFIX=1 -> exactly one entry: data=8'h74, is_ext=1, is_break=1. Same sequence with MERGE_PREFIX=0 -> three entries E0, F0, 74, all flags 0.
3. Frame 0x1C with parity bit 1 -> nothing pushed, parity_err=1. Pulse clr_err -> parity_err=0. A good frame 0x32 afterwards -> data=8'h32.
4. Send 10 good frames (0x01..0x0A) with FIFO_AW=3 and no reads -> count=8, overflow=1. Pops return 0x01..0x08 in order.
5. 4 bits of a frame, then idle for TIMEOUT_CYCLES -> frame_err=1. Next complete frame 0x2A -> data=8'h2A.
6. Pulses of ps2_clk low shorter than FILTER_LEN cycles during IDLE -> no bit sampled, count=0. Assert clrn mid-frame -> all outputs reset; the following frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame FSM states,
// scan-code prefix values and the FIFO entry layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } fifo_entry_t;

  // A PS/2 frame is good when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO head, pop, occupancy and the
// sticky error flags with their clear strobe.
interface ps2_rx_fifo_if #(
  parameter int FIFO_AW = 3
);

  logic               rd_en;
  logic               clr_err;
  logic [7:0]         data;
  logic               is_ext;
  logic               is_break;
  logic               valid;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               parity_err;
  logic               frame_err;

  modport master (
    output rd_en,
    output clr_err,
    input  data,
    input  is_ext,
    input  is_break,
    input  valid,
    input  count,
    input  overflow,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  rd_en,
    input  clr_err,
    output data,
    output is_ext,
    output is_break,
    output valid,
    output count,
    output overflow,
    output parity_err,
    output frame_err
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// Brings the raw PS/2 pins into the clk domain, debounces ps2_clk and emits a
// one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [CW-1:0] run_q, run_d;
  logic          filt_q, filt_d;

  // The run counter only advances while the synchronised clock disagrees with
  // the filtered one; any agreeing sample restarts the count.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    run_d       = '0;
    filt_d      = filt_q;
    if (clk_sync_q[1] != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      run_q       <= '0;
      filt_q      <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      run_q       <= run_d;
      filt_q      <= filt_d;
    end
  end

  assign fall      = filt_q & ~filt_d;
  assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame FSM with timeout, optional E0/F0 prefix
// folding, sticky error flags and a first-word-fall-through FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MERGE_PREFIX   = 1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_rx_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [TW-1:0]    TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  logic data_s;
  logic fall;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_s),
    .fall      (fall)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          pend_ext_q, pend_ext_d;
  logic          pend_brk_q, pend_brk_d;
  logic          push_q, push_d;
  fifo_entry_t   push_entry_q, push_entry_d;
  logic          set_parity;
  logic          set_frame;
  logic          good_par;

  // Frame reception, prefix folding and the inter-edge timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_cnt_d     = '0;
    pend_ext_d   = pend_ext_q;
    pend_brk_d   = pend_brk_q;
    push_d       = 1'b0;
    push_entry_d = push_entry_q;
    set_parity   = 1'b0;
    set_frame    = 1'b0;
    good_par     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d  = IDLE;
          good_par = odd_parity_ok(shift_q, par_q);
          set_parity = !good_par;
          set_frame  = !data_s;
          if (good_par && data_s) begin
            if (MERGE_PREFIX != 0 && shift_q == PS2_EXT) begin
              pend_ext_d = 1'b1;
            end else if (MERGE_PREFIX != 0 && shift_q == PS2_BRK) begin
              pend_brk_d = 1'b1;
            end else begin
              push_d       = 1'b1;
              push_entry_d = '{ext: pend_ext_q, brk: pend_brk_q, code: shift_q};
              pend_ext_d   = 1'b0;
              pend_brk_d   = 1'b0;
            end
          end else begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; any prefix seen before it is stale too.
    if (state_q != IDLE) begin
      if (fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        state_d    = IDLE;
        set_frame  = 1'b1;
        pend_ext_d = 1'b0;
        pend_brk_d = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  fifo_entry_t        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               parity_err_q, parity_err_d;
  logic               frame_err_q, frame_err_d;
  logic               pop;
  logic               full;
  logic               wr_en;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop      = bus.rd_en && (count_q != '0);
    full     = (count_q == FULL_COUNT);
    wr_en    = push_q && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d   = (bus.clr_err ? 1'b0 : overflow_q)   | (push_q && full && !pop);
    parity_err_d = (bus.clr_err ? 1'b0 : parity_err_q) | set_parity;
    frame_err_d  = (bus.clr_err ? 1'b0 : frame_err_q)  | set_frame;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      pend_ext_q   <= 1'b0;
      pend_brk_q   <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      pend_ext_q   <= pend_ext_d;
      pend_brk_q   <= pend_brk_d;
      push_q       <= push_d;
      push_entry_q <= push_entry_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_entry_q;
    end
  end

  fifo_entry_t head;

  // Storage is not reset, so the head is masked until an entry is present.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    bus.valid    = (count_q != '0);
    bus.data     = bus.valid ? head.code : 8'h00;
    bus.is_ext   = bus.valid & head.ext;
    bus.is_break = bus.valid & head.brk;
  end

  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule
